// File: rtl/instruction_fetcher_pkg.sv
// Shared encodings for the core/fetcher handshake plus small sizing helpers.
package instruction_fetcher_pkg;

    localparam int unsigned CORE_STATE_W    = 3;
    localparam int unsigned FETCHER_STATE_W = 2;

    // core_fsm state encoding, driven to the fetcher on core_state
    typedef enum logic [CORE_STATE_W-1:0] {
        CORE_IDLE    = 3'd0,
        CORE_FETCH   = 3'd1,
        CORE_DECODE  = 3'd2,
        CORE_REQUEST = 3'd3,
        CORE_WAIT    = 3'd4,
        CORE_EXECUTE = 3'd5,
        CORE_UPDATE  = 3'd6,
        CORE_DONE    = 3'd7
    } core_state_e;

    // fetcher progress reported back to core_fsm
    typedef enum logic [FETCHER_STATE_W-1:0] {
        FETCH_IDLE     = 2'b00,
        FETCH_FETCHING = 2'b01,
        FETCH_COMPLETE = 2'b10,
        FETCH_ERROR    = 2'b11
    } fetcher_state_e;

    // Counter width able to hold 0..timeout; at least one bit when timeout is disabled
    function automatic int unsigned timeout_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/instruction_fetcher_timeout_counter.sv
// fetch_timeout_counter: counts cycles spent waiting on memory; saturating, never wraps.
//  clk, rst_n       clock / async active-low reset
//  clear_i          zero the count (start of a new request)
//  enable_i         count this cycle (waiting, no response)
//  expired_c        combinational: final allowed wait cycle with no response
module fetch_timeout_counter
    import instruction_fetcher_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned   CNT_W    = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic          ACTIVE   = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority; a disabled timeout leaves the counter parked at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && ACTIVE && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = ACTIVE && enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: responder to core_fsm's fetch request. Reads program memory at current_pc,
// with a one-entry last-PC buffer that short-circuits repeat fetches, and a bounded memory wait.
//  clk, reset            clock / async active-low reset
//  core_state            core_fsm state (FETCH starts, DECODE acknowledges, IDLE aborts/clears error)
//  current_pc            address to fetch
//  invalidate            drop the buffered instruction
//  mem_read_valid/address/ready/data   program-memory read port
//  fetcher_state         IDLE / FETCHING / FETCH_COMPLETE / FETCH_ERROR
//  instruction           last fetched instruction
//  fetch_error           high while in FETCH_ERROR
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned TIMEOUT_CYCLES        = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CORE_STATE_W-1:0]          core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [FETCHER_STATE_W-1:0]       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_error
);

    localparam int unsigned AW = PROGRAM_MEM_ADDR_BITS;
    localparam int unsigned DW = PROGRAM_MEM_DATA_BITS;

    fetcher_state_e state_q, state_d;
    logic           valid_q, valid_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  instr_q, instr_d;
    logic           err_q, err_d;
    logic           buf_valid_q, buf_valid_d;
    logic [AW-1:0]  buf_tag_q, buf_tag_d;
    logic [DW-1:0]  buf_data_q, buf_data_d;

    logic cnt_clear, cnt_enable, expired_c;
    logic buf_hit;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (reset),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .expired_c(expired_c)
    );

    assign buf_hit    = buf_valid_q && (buf_tag_q == current_pc) && !invalidate;
    assign cnt_enable = (state_q == FETCH_FETCHING) && !mem_read_ready;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        cnt_clear   = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (buf_hit) begin
                        state_d = FETCH_COMPLETE;
                        instr_d = buf_data_q;
                    end else begin
                        state_d   = FETCH_FETCHING;
                        valid_d   = 1'b1;
                        addr_d    = current_pc;
                        cnt_clear = 1'b1;
                    end
                end
            end
            FETCH_FETCHING: begin
                // Core abort takes precedence over a response arriving in the same cycle
                if (core_state == CORE_IDLE) begin
                    state_d = FETCH_IDLE;
                    valid_d = 1'b0;
                end else if (mem_read_ready) begin
                    state_d     = FETCH_COMPLETE;
                    valid_d     = 1'b0;
                    instr_d     = mem_read_data;
                    buf_valid_d = 1'b1;
                    buf_tag_d   = addr_q;
                    buf_data_d  = mem_read_data;
                end else if (expired_c) begin
                    state_d = FETCH_ERROR;
                    valid_d = 1'b0;
                end
            end
            FETCH_COMPLETE: begin
                if (core_state == CORE_DECODE) begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_ERROR: begin
                if (core_state == CORE_IDLE) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        // Invalidate overrides any same-cycle buffer fill
        if (invalidate) begin
            buf_valid_d = 1'b0;
        end

        err_d = (state_d == FETCH_ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH_IDLE;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;
    assign fetch_error      = err_q;

endmodule
